// File: rtl/io_post_capture.sv
// io_post_capture: claims 386SX I/O cycles to the POST port window,
// terminates them with READY#, and queues each write for a sink.
module io_post_capture #(
  parameter logic [15:0] PORT_BASE   = 16'h0080,
  parameter logic [15:0] PORT_MASK   = 16'hFFFE,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned FIFO_AW     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ads_n,
  input  logic        mio,
  input  logic        dc,
  input  logic        wr,
  input  logic [1:0]  be_n,
  input  logic [22:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        claim,
  output logic        rdy_n,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [25:0] ev_data,
  output logic [7:0]  ovf_count
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_q;
  logic [1:0] be_q;
  logic [6:0] port_q;

  logic [15:0] rb_q;
  logic [7:0]  ovf_q;

  logic [25:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   fcnt_q, fcnt_d;

  logic [23:0] byte_addr;
  logic        hit;
  logic        push, pop, full, do_push, drop;

  // Address decode: 16-bit I/O window, upper byte address must be zero.
  assign byte_addr = {address, 1'b0};
  assign hit = !ads_n && !mio && dc
             && (byte_addr[23:16] == 8'h00)
             && ((byte_addr[15:0] & PORT_MASK) == (PORT_BASE & PORT_MASK));

  // Bus-cycle sequencing: claim, count wait states, one READY# clock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else cnt_d = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, wait counter and latched cycle attributes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      be_q    <= 2'b11;
      port_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && hit) begin
        wr_q   <= wr;
        be_q   <= be_n;
        port_q <= address[6:0];
      end
    end
  end

  assign claim   = (state_q == S_WAIT) || (state_q == S_DONE);
  assign rdy_n   = (state_q != S_DONE);
  assign data_oe = claim && !wr_q;

  assign push    = (state_q == S_DONE) && wr_q;
  assign pop     = ev_valid && ev_ready;
  assign full    = (fcnt_q == FULL_CNT);
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  // Occupancy changes only when exactly one of push/pop happens.
  always_comb begin
    fcnt_d = fcnt_q;
    unique case ({do_push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // FIFO pointers, occupancy, overflow counter and readback register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      ovf_q  <= 8'd0;
      rb_q   <= 16'h0000;
    end else begin
      fcnt_q <= fcnt_d;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
      if (push) begin
        if (!be_q[0]) rb_q[7:0]  <= data_in[7:0];
        if (!be_q[1]) rb_q[15:8] <= data_in[15:8];
      end
    end
  end

  // FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= {be_q, port_q, 1'b0, data_in};
  end

  assign ev_valid  = (fcnt_q != '0);
  assign ev_data   = ev_valid ? mem_q[rptr_q] : 26'd0;
  assign ovf_count = ovf_q;
  assign data_out  = rb_q;

endmodule

// File: tb/tb_io_post_capture.sv
// tb_io_post_capture: directed and random bus cycles against a
// queue-based model of the POST capture port.
module tb_io_post_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ads_n, mio, dc, wr;
  logic [1:0]  be_n;
  logic [22:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe, claim, rdy_n, ev_valid, ev_ready;
  logic [25:0] ev_data;
  logic [7:0]  ovf_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [25:0] q[$];
  logic [15:0] rb;
  int          ovf_m;

  io_post_capture dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ads_n     (ads_n),
    .mio       (mio),
    .dc        (dc),
    .wr        (wr),
    .be_n      (be_n),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .claim     (claim),
    .rdy_n     (rdy_n),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_data   (ev_data),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_valid"}, 32'(ev_valid), 32'(q.size() != 0));
    chk({tag, "_data"}, 32'(ev_data), q.size() != 0 ? 32'(q[0]) : 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_count), 32'(ovf_m));
    chk({tag, "_rb"}, 32'(data_out), 32'(rb));
  endtask

  // One complete CPU bus cycle; pop=1 raises ev_ready on the
  // edge where a claimed write would complete.
  task automatic bus(input logic m, input logic d, input logic w,
                     input logic [1:0] be, input logic [22:0] a,
                     input logic [15:0] dat, input bit pop);
    logic [23:0] ba;
    bit          hit;
    ba  = {a, 1'b0};
    hit = !m && d && ba[23:16] == 8'h00 && ba[15:1] == 15'h0040;
    @(negedge clk);
    ads_n = 1'b0; mio = m; dc = d; wr = w;
    be_n = be; address = a; data_in = dat;
    @(posedge clk);
    @(negedge clk);
    ads_n = 1'b1;
    mio = 1'($urandom); dc = 1'($urandom); wr = 1'($urandom);
    be_n = 2'($urandom); address = 23'($urandom);
    chk("claim_w1", 32'(claim), 32'(hit));
    chk("rdy_w1", 32'(rdy_n), 32'd1);
    chk("oe_w1", 32'(data_oe), 32'(hit && !w));
    if (hit && !w) chk("rd_data", 32'(data_out), 32'(rb));
    @(posedge clk);
    @(negedge clk);
    chk("claim_w2", 32'(claim), 32'(hit));
    chk("rdy_w2", 32'(rdy_n), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rdy_done", 32'(rdy_n), 32'(!hit));
    chk("claim_done", 32'(claim), 32'(hit));
    if (pop) begin
      if (q.size() != 0) chk("head_pop", 32'(ev_data), 32'(q[0]));
      ev_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    ev_ready = 1'b0;
    chk("rdy_after", 32'(rdy_n), 32'd1);
    chk("claim_after", 32'(claim), 32'd0);
    if (pop && q.size() != 0) void'(q.pop_front());
    if (hit && w) begin
      if (!be[0]) rb[7:0] = dat[7:0];
      if (!be[1]) rb[15:8] = dat[15:8];
      if (q.size() < 8) q.push_back({be, a[6:0], 1'b0, dat});
      else if (ovf_m < 255) ovf_m++;
    end
    chk_state("post");
  endtask

  task automatic drain();
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("drain_valid", 32'(ev_valid), 32'd1);
      chk("drain_data", 32'(ev_data), 32'(q[0]));
      ev_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ev_ready = 1'b0;
      void'(q.pop_front());
    end
    chk("drain_empty", 32'(ev_valid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; ads_n = 1'b1; mio = 1'b0; dc = 1'b0; wr = 1'b0;
    be_n = 2'b11; address = '0; data_in = '0; ev_ready = 1'b0;
    rb = 16'h0000; ovf_m = 0;
    #1;
    chk("rst_rdy", 32'(rdy_n), 32'd1);
    chk("rst_claim", 32'(claim), 32'd0);
    chk("rst_oe", 32'(data_oe), 32'd0);
    chk_state("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    bus(1'b0, 1'b1, 1'b1, 2'b10, 23'h40, 16'h00A5, 1'b0);
    chk("first_ev", 32'(ev_data), 32'({2'b10, 8'h80, 16'h00A5}));
    chk("first_rb", 32'(data_out), 32'h00A5);
    bus(1'b0, 1'b1, 1'b0, 2'b00, 23'h40, 16'h1234, 1'b0);
    bus(1'b1, 1'b1, 1'b0, 2'b00, 23'h7FFFF8, 16'h0000, 1'b0);
    bus(1'b0, 1'b1, 1'b1, 2'b00, 23'h42, 16'hBEEF, 1'b0);
    drain();

    for (int i = 1; i <= 9; i++)
      bus(1'b0, 1'b1, 1'b1, 2'b00, 23'h40, 16'(i), 1'b0);
    chk("ovf_9", 32'(ovf_count), 32'd1);
    chk("rb_9", 32'(data_out), 32'h0009);
    chk("head_1", 32'(ev_data[15:0]), 32'h0001);
    drain();

    for (int i = 0; i < 8; i++)
      bus(1'b0, 1'b1, 1'b1, 2'b00, 23'h40, 16'(16'h10 + i), 1'b0);
    bus(1'b0, 1'b1, 1'b1, 2'b01, 23'h40, 16'h5555, 1'b1);
    chk("full_pp_ovf", 32'(ovf_count), 32'd1);
    chk("full_pp_n", 32'(q.size()), 32'd8);
    drain();

    @(negedge clk);
    ads_n = 1'b0; mio = 1'b0; dc = 1'b1; wr = 1'b0;
    be_n = 2'b00; address = 23'h40;
    @(posedge clk);
    @(negedge clk);
    ads_n = 1'b1;
    chk("mid_claim", 32'(claim), 32'd1);
    chk("mid_oe", 32'(data_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    q.delete(); rb = 16'h0000; ovf_m = 0;
    chk("mrst_rdy", 32'(rdy_n), 32'd1);
    chk("mrst_claim", 32'(claim), 32'd0);
    chk("mrst_oe", 32'(data_oe), 32'd0);
    chk_state("mrst");
    @(negedge clk);
    reset_n = 1'b1;
    bus(1'b0, 1'b1, 1'b1, 2'b11, 23'h40, 16'hCAFE, 1'b0);
    bus(1'b0, 1'b1, 1'b1, 2'b01, 23'h40, 16'hCAFE, 1'b0);

    for (int it = 0; it < 150; it++) begin
      int unsigned r;
      bit          p;
      r = $urandom_range(0, 9);
      p = ($urandom_range(0, 3) == 0);
      unique case (r)
        0, 1, 2, 3:
          bus(1'b0, 1'b1, 1'b1, 2'($urandom), 23'h40, 16'($urandom), p);
        4: bus(1'b0, 1'b1, 1'b0, 2'($urandom), 23'h40, 16'($urandom), p);
        5: bus(1'b0, 1'b1, 1'($urandom), 2'($urandom),
               23'($urandom) | 23'h1, 16'($urandom), p);
        6: bus(1'b1, 1'b1, 1'($urandom), 2'($urandom), 23'h40,
               16'($urandom), p);
        7: bus(1'b0, 1'b0, 1'($urandom), 2'($urandom), 23'h40,
               16'($urandom), p);
        8: bus(1'b1, 1'b0, 1'($urandom), 2'($urandom), 23'h40,
               16'($urandom), p);
        default: drain();
      endcase
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
